// File: rtl/ntt_seq_ctrl.sv
// rtl/ntt_seq_ctrl.sv - pass sequencer for the mixed-radix NTT address/enable FSM
// Walks radix-2 pass, drain, radix-4 pass, drain; watchdog guards each radix pass.
module ntt_seq_ctrl #(
   parameter int unsigned DRAIN2 = 9,
   parameter int unsigned DRAIN4 = 15,
   parameter int unsigned WDOG   = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_radix4_only,
   input  logic        i_abort,
   input  logic [1:0]  i_done_flag,
   output logic [2:0]  o_conf,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [15:0] o_cycles
);

   typedef enum logic [2:0] {
      S_IDLE, S_R2, S_DR2, S_R4, S_DR4, S_DONE, S_ERR
   } state_t;

   localparam logic [7:0] LP_DR2_LAST  = 8'(DRAIN2 - 1);
   localparam logic [7:0] LP_DR4_LAST  = 8'(DRAIN4 - 1);
   localparam logic [7:0] LP_WDOG_LAST = 8'(WDOG - 1);

   state_t      r_state;
   logic [7:0]  r_phase;
   logic [2:0]  r_conf;
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic [15:0] r_cycles;

   state_t      w_next;
   logic        w_launch;
   logic [7:0]  w_phase;
   logic [2:0]  w_conf;
   logic        w_busy;
   logic        w_done;
   logic        w_err;
   logic [15:0] w_cycles;

   always_comb begin
      w_next   = r_state;
      w_launch = 1'b0;
      case (r_state)
         S_IDLE, S_ERR: begin
            if (i_start) begin
               w_launch = 1'b1;
               w_next   = i_radix4_only ? S_R4 : S_R2;
            end
         end
         // The expected flag is checked first so it wins a tie with the watchdog.
         S_R2: begin
            if (i_done_flag == 2'b01)          w_next = S_DR2;
            else if (r_phase == LP_WDOG_LAST)  w_next = S_ERR;
         end
         S_DR2: if (r_phase == LP_DR2_LAST) w_next = S_R4;
         S_R4: begin
            if (i_done_flag == 2'b10)          w_next = S_DR4;
            else if (r_phase == LP_WDOG_LAST)  w_next = S_ERR;
         end
         S_DR4: if (r_phase == LP_DR4_LAST) w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (i_abort && (r_state != S_IDLE)) begin
         w_next   = S_IDLE;
         w_launch = 1'b0;
      end
   end

   // Outputs are decoded from the next state so they register on the same edge.
   always_comb begin
      w_conf = 3'b000;
      w_busy = 1'b0;
      w_done = 1'b0;
      w_err  = 1'b0;
      case (w_next)
         S_R2:    begin w_conf = 3'b001; w_busy = 1'b1; end
         S_DR2:   begin w_conf = 3'b011; w_busy = 1'b1; end
         S_R4:    begin w_conf = 3'b010; w_busy = 1'b1; end
         S_DR4:   begin w_conf = 3'b100; w_busy = 1'b1; end
         S_DONE:  begin w_done = 1'b1;   w_busy = 1'b1; end
         S_ERR:   w_err = 1'b1;
         default: w_conf = 3'b000;
      endcase
   end

   always_comb begin
      w_phase = r_phase;
      if (w_next != r_state)
         w_phase = 8'd0;
      else if (r_state == S_R2 || r_state == S_DR2 || r_state == S_R4 || r_state == S_DR4)
         w_phase = r_phase + 8'd1;
   end

   always_comb begin
      w_cycles = r_cycles;
      if (w_launch)
         w_cycles = 16'd0;
      else if (r_busy && (r_cycles != 16'hFFFF))
         w_cycles = r_cycles + 16'd1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_phase  <= 8'd0;
         r_conf   <= 3'b000;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_cycles <= 16'd0;
      end else begin
         r_state  <= w_next;
         r_phase  <= w_phase;
         r_conf   <= w_conf;
         r_busy   <= w_busy;
         r_done   <= w_done;
         r_err    <= w_err;
         r_cycles <= w_cycles;
      end
   end

   assign o_conf   = r_conf;
   assign o_busy   = r_busy;
   assign o_done   = r_done;
   assign o_err    = r_err;
   assign o_cycles = r_cycles;

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// tb/tb_ntt_seq_ctrl.sv - scoreboard bench for ntt_seq_ctrl
// Expected conf segments are queued at launch and popped as the monitor sees each segment end.
module tb_ntt_seq_ctrl;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_start;
   logic        i_radix4_only;
   logic        i_abort;
   logic [1:0]  i_done_flag;
   logic [2:0]  o_conf;
   logic        o_busy;
   logic        o_done;
   logic        o_err;
   logic [15:0] o_cycles;

   typedef struct {
      logic [2:0] conf;
      int         len;
   } seg_t;

   seg_t       exp_q[$];
   seg_t       e;
   int         total = 0;
   int         bad = 0;
   int         done_cnt = 0;
   int         err_cnt = 0;
   logic [2:0] cur_conf = 3'd0;
   int         cur_len = 0;
   logic       prev_done = 1'b0;

   ntt_seq_ctrl #(.DRAIN2(9), .DRAIN4(15), .WDOG(255)) dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .i_start       (i_start),
      .i_radix4_only (i_radix4_only),
      .i_abort       (i_abort),
      .i_done_flag   (i_done_flag),
      .o_conf        (o_conf),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_err         (o_err),
      .o_cycles      (o_cycles)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   // Segment monitor: run-length encodes conf and scores each finished non-zero segment.
   always @(negedge clk) begin
      if (o_done) begin
         done_cnt++;
         total++;
         if (!(o_busy === 1'b1 && o_conf === 3'd0 && prev_done === 1'b0)) begin
            bad++;
            $display("FAIL done_shape: busy=%b conf=%0d prev_done=%b, required busy=1 conf=0 prev_done=0",
                     o_busy, o_conf, prev_done);
         end
      end
      prev_done = o_done;
      if (o_err === 1'b1) err_cnt++;
      if (o_conf === cur_conf) begin
         cur_len++;
      end else begin
         if (cur_conf !== 3'd0) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL seg_unexpected: got conf=%0d len=%0d, required no segment", cur_conf, cur_len);
            end else begin
               e = exp_q.pop_front();
               if (e.conf !== cur_conf || e.len !== cur_len) begin
                  bad++;
                  $display("FAIL seg: got conf=%0d len=%0d, required conf=%0d len=%0d",
                           cur_conf, cur_len, e.conf, e.len);
               end
            end
         end
         cur_conf = o_conf;
         cur_len  = 1;
      end
   end

   task automatic push_seg(input logic [2:0] c, input int n);
      seg_t s;
      s.conf = c;
      s.len  = n;
      exp_q.push_back(s);
   endtask

   task automatic wait_conf(input logic [2:0] v, input int budget);
      int n = 0;
      while (o_conf !== v && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (o_conf !== v) begin
         total++;
         bad++;
         $display("FAIL wait_conf: conf=%0d after %0d cycles, required %0d", o_conf, n, v);
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (o_busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (o_busy !== 1'b0) begin
         total++;
         bad++;
         $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", o_busy, n);
      end
   endtask

   task automatic launch(input logic r4);
      i_radix4_only = r4;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   // Flag presented so it is sampled at the end of the n-th cycle of conf==c.
   task automatic pulse_flag(input logic [2:0] c, input logic [1:0] f, input int n);
      wait_conf(c, 20);
      repeat (n - 1) @(negedge clk);
      i_done_flag = f;
      @(negedge clk);
      i_done_flag = 2'b00;
   endtask

   task automatic test_reset;
      i_rst = 1'b1; i_start = 1'b0; i_radix4_only = 1'b0; i_abort = 1'b0; i_done_flag = 2'b00;
      repeat (3) @(negedge clk);
      total++;
      if ({o_conf, o_busy, o_done, o_err, o_cycles} !== 22'd0) begin
         bad++;
         $display("FAIL reset_hold: conf=%0d busy=%b done=%b err=%b cycles=%0d, required all 0",
                  o_conf, o_busy, o_done, o_err, o_cycles);
      end
      i_rst = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({o_conf, o_busy, o_done, o_err, o_cycles} !== 22'd0) begin
         bad++;
         $display("FAIL reset_idle: conf=%0d busy=%b done=%b err=%b cycles=%0d, required all 0",
                  o_conf, o_busy, o_done, o_err, o_cycles);
      end
   endtask

   task automatic test_full_run;
      int d0 = done_cnt;
      push_seg(3'd1, 32); push_seg(3'd3, 9); push_seg(3'd2, 96); push_seg(3'd4, 15);
      launch(1'b0);
      total++;
      if (o_conf !== 3'd1 || o_busy !== 1'b1) begin
         bad++;
         $display("FAIL start_latency: conf=%0d busy=%b, required conf=1 busy=1", o_conf, o_busy);
      end
      pulse_flag(3'd1, 2'b01, 32);
      pulse_flag(3'd2, 2'b10, 96);
      wait_idle(40);
      @(negedge clk);
      total++;
      if (o_cycles !== 16'd153) begin
         bad++;
         $display("FAIL full_cycles: got %0d, required 153", o_cycles);
      end
      total++;
      if (done_cnt - d0 !== 1) begin
         bad++;
         $display("FAIL full_done_count: got %0d, required 1", done_cnt - d0);
      end
      total++;
      if (exp_q.size() !== 0) begin
         bad++;
         $display("FAIL full_segments_left: got %0d, required 0", exp_q.size());
      end
   endtask

   task automatic test_radix4_only;
      int d0 = done_cnt;
      push_seg(3'd2, 96); push_seg(3'd4, 15);
      launch(1'b1);
      total++;
      if (o_conf !== 3'd2) begin
         bad++;
         $display("FAIL r4_start: conf=%0d, required 2", o_conf);
      end
      pulse_flag(3'd2, 2'b10, 96);
      wait_idle(40);
      @(negedge clk);
      total++;
      if (o_cycles !== 16'd112 || done_cnt - d0 !== 1 || exp_q.size() !== 0) begin
         bad++;
         $display("FAIL r4_result: cycles=%0d dones=%0d left=%0d, required 112 1 0",
                  o_cycles, done_cnt - d0, exp_q.size());
      end
   endtask

   task automatic test_watchdog;
      int n = 0;
      int d0 = done_cnt;
      push_seg(3'd1, 255);
      launch(1'b0);
      while (o_err !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n !== 255 || o_err !== 1'b1) begin
         bad++;
         $display("FAIL wdog_timing: err=%b after %0d cycles, required err=1 after 255", o_err, n);
      end
      repeat (3) @(negedge clk);
      total++;
      if (o_err !== 1'b1 || o_conf !== 3'd0 || o_busy !== 1'b0 || o_cycles !== 16'd255) begin
         bad++;
         $display("FAIL wdog_hold: err=%b conf=%0d busy=%b cycles=%0d, required 1 0 0 255",
                  o_err, o_conf, o_busy, o_cycles);
      end
      push_seg(3'd2, 96); push_seg(3'd4, 15);
      launch(1'b1);
      total++;
      if (o_err !== 1'b0 || o_conf !== 3'd2 || o_busy !== 1'b1) begin
         bad++;
         $display("FAIL wdog_restart: err=%b conf=%0d busy=%b, required 0 2 1", o_err, o_conf, o_busy);
      end
      pulse_flag(3'd2, 2'b10, 96);
      wait_idle(40);
      @(negedge clk);
      total++;
      if (o_cycles !== 16'd112 || done_cnt - d0 !== 1 || exp_q.size() !== 0) begin
         bad++;
         $display("FAIL wdog_rerun: cycles=%0d dones=%0d left=%0d, required 112 1 0",
                  o_cycles, done_cnt - d0, exp_q.size());
      end
   endtask

   task automatic test_flag_wdog_tie;
      int d0 = done_cnt;
      int e0 = err_cnt;
      push_seg(3'd1, 255); push_seg(3'd3, 9); push_seg(3'd2, 10); push_seg(3'd4, 15);
      launch(1'b0);
      pulse_flag(3'd1, 2'b01, 255);
      pulse_flag(3'd2, 2'b10, 10);
      wait_idle(40);
      @(negedge clk);
      total++;
      if (err_cnt !== e0) begin
         bad++;
         $display("FAIL tie_err: err cycles=%0d, required 0", err_cnt - e0);
      end
      total++;
      if (o_cycles !== 16'd290 || done_cnt - d0 !== 1 || exp_q.size() !== 0) begin
         bad++;
         $display("FAIL tie_result: cycles=%0d dones=%0d left=%0d, required 290 1 0",
                  o_cycles, done_cnt - d0, exp_q.size());
      end
   endtask

   task automatic test_abort;
      int d0 = done_cnt;
      push_seg(3'd1, 5); push_seg(3'd3, 9); push_seg(3'd2, 20);
      i_radix4_only = 1'b0;
      i_start = 1'b1;
      @(negedge clk);
      pulse_flag(3'd1, 2'b01, 5);
      wait_conf(3'd2, 20);
      repeat (19) @(negedge clk);
      i_abort = 1'b1;
      i_done_flag = 2'b10;
      @(negedge clk);
      total++;
      if (o_conf !== 3'd0 || o_busy !== 1'b0 || o_cycles !== 16'd34) begin
         bad++;
         $display("FAIL abort_now: conf=%0d busy=%b cycles=%0d, required 0 0 34", o_conf, o_busy, o_cycles);
      end
      i_abort = 1'b0; i_start = 1'b0; i_done_flag = 2'b00;
      repeat (5) @(negedge clk);
      total++;
      if (o_cycles !== 16'd34 || o_conf !== 3'd0 || o_busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_frozen: cycles=%0d conf=%0d busy=%b, required 34 0 0", o_cycles, o_conf, o_busy);
      end
      total++;
      if (done_cnt - d0 !== 0 || exp_q.size() !== 0) begin
         bad++;
         $display("FAIL abort_result: dones=%0d left=%0d, required 0 0", done_cnt - d0, exp_q.size());
      end
   endtask

   task automatic test_async_reset;
      int d0 = done_cnt;
      push_seg(3'd1, 10); push_seg(3'd3, 9); push_seg(3'd2, 8); push_seg(3'd4, 5);
      launch(1'b0);
      wait_conf(3'd1, 20);
      i_done_flag = 2'b10;
      repeat (9) @(negedge clk);
      i_done_flag = 2'b01;
      @(negedge clk);
      i_done_flag = 2'b00;
      pulse_flag(3'd2, 2'b10, 8);
      wait_conf(3'd4, 20);
      repeat (4) @(negedge clk);
      #2 i_rst = 1'b1;
      #1;
      total++;
      if ({o_conf, o_busy, o_done, o_err, o_cycles} !== 22'd0) begin
         bad++;
         $display("FAIL async_reset: conf=%0d busy=%b done=%b err=%b cycles=%0d, required all 0",
                  o_conf, o_busy, o_done, o_err, o_cycles);
      end
      @(negedge clk);
      i_rst = 1'b0;
      repeat (20) @(negedge clk);
      total++;
      if (done_cnt - d0 !== 0 || exp_q.size() !== 0 || o_busy !== 1'b0) begin
         bad++;
         $display("FAIL async_after: dones=%0d left=%0d busy=%b, required 0 0 0",
                  done_cnt - d0, exp_q.size(), o_busy);
      end
      push_seg(3'd2, 4); push_seg(3'd4, 15);
      launch(1'b1);
      pulse_flag(3'd2, 2'b10, 4);
      wait_idle(40);
      @(negedge clk);
      total++;
      if (o_cycles !== 16'd20 || done_cnt - d0 !== 1 || exp_q.size() !== 0) begin
         bad++;
         $display("FAIL async_recover: cycles=%0d dones=%0d left=%0d, required 20 1 0",
                  o_cycles, done_cnt - d0, exp_q.size());
      end
   endtask

   initial begin
      i_rst = 1'b1;
      test_reset();
      test_full_run();
      test_radix4_only();
      test_watchdog();
      test_flag_wdog_tie();
      test_abort();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ntt_seq_ctrl.md
# ntt_seq_ctrl

Top-level sequencer for the mixed-radix NTT address/enable FSM. It drives that FSM's 3-bit `conf` input through a complete transform: a radix-2 pass, a pipeline drain, a radix-4 pass, and a final drain. It then reports completion with a one-cycle `done` pulse. It sits between the host/start logic and the FSM, consuming the FSM's `done_flag` and guarding each pass with a watchdog.

## Interface

**Parameters**
- `DRAIN2`, default 9: cycles held in DONE_RADIX2 so the radix-2 write pipeline (8-stage delay plus register) empties.
- `DRAIN4`, default 15: cycles held in DONE_RADIX4 so the radix-4 write pipeline (14-stage delay plus register) empties.
- `WDOG`, default 255: maximum cycles allowed in one radix pass before an error is declared; range 1..255.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a transform; sampled only in IDLE or ERR.
- `radix4_only` in 1: sampled with `start`; 1 skips the radix-2 pass and its drain.
- `abort` in 1: synchronous abort; returns to IDLE.
- `done_flag` in 2: from the FSM; 2'b01 means radix-2 finished, 2'b10 means radix-4 finished.
- `conf` out 3: to the FSM. Encoding: IDLE=000, RADIX2=001, RADIX4=010, DONE_RADIX2=011, DONE_RADIX4=100. Registered.
- `busy` out 1: high in every state except IDLE and ERR. Registered.
- `done` out 1: one-cycle pulse when the transform completes.
- `err` out 1: high while in ERR (watchdog expired).
- `cycles` out 16: count of busy cycles in the current or last run; saturates at 16'hFFFF.

## Operation

**States:** S_IDLE, S_R2, S_DR2, S_R4, S_DR4, S_DONE, S_ERR. `conf` is a registered decode of the state:
- S_R2 → 001; S_DR2 → 011; S_R4 → 010; S_DR4 → 100.
- S_IDLE, S_DONE, S_ERR → 000.

**Transitions:**
- S_IDLE: `start`=1 → S_R4 if `radix4_only`, else S_R2. Clear `cycles` and the phase counter.
- S_R2: `done_flag`==2'b01 → S_DR2; watchdog expiry → S_ERR.
- S_DR2: after exactly `DRAIN2` cycles in the state → S_R4.
- S_R4: `done_flag`==2'b10 → S_DR4; watchdog expiry → S_ERR.
- S_DR4: after exactly `DRAIN4` cycles → S_DONE.
- S_DONE: one cycle with `done`=1, then S_IDLE.
- S_ERR: hold until `start`=1. Then clear `err` and launch as from IDLE, including the `radix4_only` choice.

**Flag handling:**
- `done_flag` values other than the expected one for the current state are ignored.
- `done_flag` is ignored in all states other than S_R2 and S_R4.

**Phase counter:** 8 bits, reset to 0 on every state entry.
- Increments each cycle in S_R2, S_R4, S_DR2 and S_DR4.
- Watchdog expires when the counter equals `WDOG` - 1 in S_R2/S_R4 and the expected flag is absent.
- If the expected flag and watchdog expiry occur in the same cycle, the flag wins.

**Abort:** `abort`=1 in any state except S_IDLE → S_IDLE next cycle, with `conf`=000 and no `done` pulse.
- `cycles` keeps its value.
- `abort` has priority over `start` and over `done_flag`.
- In S_ERR, `abort` also clears `err`.

**`start` while busy:** ignored; no queueing.

**`cycles`:** increments by 1 each cycle `busy`=1, saturating at 16'hFFFF. It holds its value after done/abort/error until the next accepted `start`.

## Timing

**Reset values:** state S_IDLE; `conf`=000, `busy`=0, `done`=0, `err`=0, `cycles`=0, phase counter 0. `rst` asserted mid-run takes effect immediately and asynchronously; no `done` pulse is produced.

**Start latency:** `start` sampled on edge N → `conf`=001 (or 010) and `busy`=1 from edge N+1.

**Flag latency:** `done_flag` sampled on edge M → the new `conf` is visible from edge M+1.

**Drain length:** `conf`=011 is held for exactly `DRAIN2` cycles and `conf`=100 for exactly `DRAIN4` cycles.

**Completion:** `done`=1 is a single cycle, coincident with `busy`=1 and `conf`=000. `busy` falls on the following edge.

**Run length:** cycles from the first `busy`=1 to the `done` cycle inclusive = R2 cycles + `DRAIN2` + R4 cycles + `DRAIN4` + 1. Here R2 and R4 are the cycles spent in each pass, including the cycle the flag is sampled.

**`err`:** asserts on the edge after expiry and stays high while in S_ERR.

## Test plan

- **Full run (defaults):** `start` with `radix4_only`=0; bench drives `done_flag`=01 on the 32nd S_R2 cycle and 10 on the 96th S_R4 cycle → `conf` sequence 001×32, 011×9, 010×96, 100×15. Then `done` pulses once and `cycles`=153.
- **Radix-4 only:** `radix4_only`=1, flag 10 after 96 cycles → no 001/011 cycles, `cycles`=112, single `done`.
- **Watchdog:** `WDOG`=255, never assert `done_flag` in S_R2 → `err`=1 after 255 R2 cycles, `conf`=000, `busy`=0. A following `start` clears `err` and restarts.
- **Flag/watchdog tie:** assert 01 exactly on the expiry cycle → S_DR2 entered, `err` stays 0.
- **Abort and restart:** `abort` during S_R4 → `conf`=000 next cycle, no `done`, `cycles` frozen; `start` held high during the run is ignored until S_IDLE.
- **Async reset mid-drain:** `rst` pulsed during S_DR4 → all outputs at reset values immediately; a wrong flag value (10 in S_R2) has no effect.
